branch_pred_ctrl: RTL and testbench

//  Branch direction predictor and misprediction-recovery sequencer for the branch-target queue.

---
 rtl/branch_pred_ctrl_if.sv | 26 ++
 rtl/branch_pred_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_branch_pred_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/branch_pred_ctrl_if.sv
// Fetch/execute-side signal bundle of the branch predictor: IF/EX inputs in,
// prediction, redirect and flush controls out.
interface branch_pred_ctrl_if;
  logic        Istall;
  logic        Dstall;
  logic [6:0]  opcode_IF;
  logic [31:0] pc_IF;
  logic        ex_br_valid;
  logic        ex_br_taken;
  logic        taken_sel;
  logic [1:0]  pc_sel;
  logic        flush_IF_ID;
  logic        flush_ID_EX;
  logic        fetch_hold;
  logic [15:0] mispredict_cnt;

  modport master (
    output Istall, Dstall, opcode_IF, pc_IF, ex_br_valid, ex_br_taken,
    input  taken_sel, pc_sel, flush_IF_ID, flush_ID_EX, fetch_hold, mispredict_cnt
  );

  modport slave (
    input  Istall, Dstall, opcode_IF, pc_IF, ex_br_valid, ex_br_taken,
    output taken_sel, pc_sel, flush_IF_ID, flush_ID_EX, fetch_hold, mispredict_cnt
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// 2-bit-counter BHT branch predictor with an IF->EX outstanding-branch FIFO and a
// one-cycle RECOVER state that redirects fetch and flushes the front end.
module branch_pred_ctrl #(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int OUT_DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_pred_ctrl_if.slave bp
);
  localparam int          PTR_W    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int          CNT_W    = $clog2(OUT_DEPTH + 1);
  localparam logic [6:0]  OP_BTYPE = 7'b1100011;
  localparam logic [6:0]  OP_JTYPE = 7'b1101111;

  typedef enum logic {S_NORMAL, S_RECOVER} state_e;

  state_e             state_q, state_d;
  logic [1:0]         bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0]   fifo_idx_q  [OUT_DEPTH];
  logic               fifo_pred_q [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               taken_sel_q, taken_sel_d;
  logic [1:0]         pc_sel_q, pc_sel_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               stall, is_b, is_j, pred, normal;
  logic [IDX_W-1:0]   if_idx, head_idx;
  logic               head_pred, pop, mispredict, full, fetch_hold;
  logic               accept_b, push, clear;
  logic [1:0]         bht_cur, bht_new;
  logic [BHT_ENTRIES-1:0] bht_we;
  logic [OUT_DEPTH-1:0]   fifo_we;
  logic               unused_pc_bits;

  assign stall      = bp.Istall | bp.Dstall;
  assign is_b       = (bp.opcode_IF == OP_BTYPE);
  assign is_j       = (bp.opcode_IF == OP_JTYPE);
  assign normal     = (state_q == S_NORMAL);
  assign if_idx     = bp.pc_IF[IDX_W+1:2];
  assign pred       = bht_q[if_idx][1];
  assign unused_pc_bits = ^{bp.pc_IF[31:IDX_W+2], bp.pc_IF[1:0]};

  assign head_idx   = fifo_idx_q[rd_ptr_q];
  assign head_pred  = fifo_pred_q[rd_ptr_q];
  // Resolutions arriving while RECOVER is flushing the pipe are wrong-path and ignored.
  assign pop        = normal & bp.ex_br_valid & ~stall & (count_q != '0);
  assign mispredict = pop & (head_pred != bp.ex_br_taken);
  assign full       = (count_q == CNT_W'(OUT_DEPTH));
  assign fetch_hold = full & is_b & ~(pop & ~mispredict);
  assign accept_b   = normal & ~stall & is_b & ~fetch_hold;
  assign push       = accept_b & ~mispredict;
  assign clear      = (state_q == S_RECOVER) & ~stall;

  assign bht_cur = bht_q[head_idx];
  always_comb begin
    bht_new = bht_cur;
    if (bp.ex_br_taken) begin
      if (bht_cur != 2'b11) bht_new = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_new = bht_cur - 2'b01;
    end
  end

  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht_we
      assign bht_we[gi] = pop & (head_idx == IDX_W'(gi));
    end
    for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_fifo_we
      assign fifo_we[gi] = push & (wr_ptr_q == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        if (bht_we[i]) bht_q[i] <= bht_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_idx_q[i]  <= '0;
        fifo_pred_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < OUT_DEPTH; i++)
        if (fifo_we[i]) begin
          fifo_idx_q[i]  <= if_idx;
          fifo_pred_q[i] <= pred;
        end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_NORMAL;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        S_NORMAL:  if (mispredict) state_d = S_RECOVER;
        S_RECOVER: state_d = S_NORMAL;
        default:   state_d = S_NORMAL;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    bp.flush_IF_ID = (state_q == S_RECOVER);
    bp.flush_ID_EX = (state_q == S_RECOVER);
  end

  always_comb begin
    taken_sel_d = taken_sel_q;
    pc_sel_d    = pc_sel_q;
    cnt_d       = cnt_q;
    if (!stall) begin
      if (!normal) begin
        taken_sel_d = 1'b0;
        pc_sel_d    = 2'd0;
      end else begin
        taken_sel_d = is_j | (accept_b & pred);
        if (mispredict)                    pc_sel_d = 2'd2;
        else if (is_j | (accept_b & pred)) pc_sel_d = 2'd1;
        else                               pc_sel_d = 2'd0;
      end
    end
    if (mispredict && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      taken_sel_q <= 1'b0;
      pc_sel_q    <= 2'd0;
      cnt_q       <= 16'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      taken_sel_q <= taken_sel_d;
      pc_sel_q    <= pc_sel_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bp.taken_sel      = taken_sel_q;
  assign bp.pc_sel         = pc_sel_q;
  assign bp.fetch_hold     = fetch_hold;
  assign bp.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench: the driver pushes reference-model expectations per cycle,
// a separate monitor pops them and compares against the DUT outputs.
module tb_branch_pred_ctrl;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_ALU = 7'b0010011;
  localparam int         DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_pred_ctrl_if bp_if ();
  branch_pred_ctrl #(.BHT_ENTRIES(16), .IDX_W(4), .OUT_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bp   (bp_if)
  );

  typedef struct { int idx; bit pred; } ent_t;
  typedef struct { bit taken; int pcsel; bit flush; bit hold; int cnt; } exp_t;

  int   m_bht [16];
  ent_t m_fifo [$];
  bit   m_rec;
  bit   m_taken;
  int   m_pcsel;
  int   m_cnt;
  exp_t sb [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic model_reset();
    foreach (m_bht[i]) m_bht[i] = 1;
    m_fifo.delete();
    m_rec = 0; m_taken = 0; m_pcsel = 0; m_cnt = 0;
  endtask

  task automatic cycle(input bit rst_a, input bit is, input bit ds, input logic [6:0] op,
                       input logic [31:0] pc, input bit exv, input bit ext);
    bit   stall, isb, isj, pop_ok, mis, hold, pred, accept;
    int   idx;
    ent_t h;
    exp_t e;
    @(negedge clk);
    bp_if.Istall = is; bp_if.Dstall = ds; bp_if.opcode_IF = op; bp_if.pc_IF = pc;
    bp_if.ex_br_valid = exv; bp_if.ex_br_taken = ext;
    rst_n = !rst_a;
    if (rst_a) begin
      model_reset();
      e = '{taken: 0, pcsel: 0, flush: 0, hold: 0, cnt: 0};
      sb.push_back(e);
      return;
    end
    stall  = is | ds;
    isb    = (op == OP_B);
    isj    = (op == OP_J);
    pop_ok = !m_rec && exv && !stall && m_fifo.size() > 0;
    mis    = pop_ok && (m_fifo[0].pred != ext);
    hold   = (m_fifo.size() == DEPTH) && isb && !(pop_ok && !mis);
    e = '{taken: m_taken, pcsel: m_pcsel, flush: m_rec, hold: hold, cnt: m_cnt};
    sb.push_back(e);
    if (stall) return;
    if (m_rec) begin
      m_fifo.delete();
      m_rec = 0; m_taken = 0; m_pcsel = 0;
      return;
    end
    idx  = (pc >> 2) % 16;
    pred = (m_bht[idx] >= 2);
    if (pop_ok) begin
      h = m_fifo.pop_front();
      m_bht[h.idx] = ext ? ((m_bht[h.idx] < 3) ? m_bht[h.idx] + 1 : 3)
                         : ((m_bht[h.idx] > 0) ? m_bht[h.idx] - 1 : 0);
      if (mis) begin
        m_rec = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    accept = isb && !hold;
    if (accept && !mis) m_fifo.push_back('{idx: idx, pred: pred});
    m_taken = isj || (accept && pred);
    m_pcsel = mis ? 2 : ((isj || (accept && pred)) ? 1 : 0);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL cycle %0d %s: got %0d expected %0d", cyc, name, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cyc++;
        chk("taken_sel", int'(bp_if.taken_sel), int'(e.taken));
        chk("pc_sel", int'(bp_if.pc_sel), e.pcsel);
        chk("flush_IF_ID", int'(bp_if.flush_IF_ID), int'(e.flush));
        chk("flush_ID_EX", int'(bp_if.flush_ID_EX), int'(e.flush));
        chk("fetch_hold", int'(bp_if.fetch_hold), int'(e.hold));
        chk("mispredict_cnt", int'(bp_if.mispredict_cnt), e.cnt);
        $display("txn %0d: rst_n=%0d op=%h pc=%h exv=%0d ext=%0d -> taken=%0d pc_sel=%0d flush=%0d hold=%0d cnt=%0d",
                 cyc, rst_n, bp_if.opcode_IF, bp_if.pc_IF, bp_if.ex_br_valid, bp_if.ex_br_taken,
                 bp_if.taken_sel, bp_if.pc_sel, bp_if.flush_IF_ID, bp_if.fetch_hold, bp_if.mispredict_cnt);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int r;
    logic [6:0] op;
    bp_if.Istall = 0; bp_if.Dstall = 0; bp_if.opcode_IF = OP_ALU; bp_if.pc_IF = 0;
    bp_if.ex_br_valid = 0; bp_if.ex_br_taken = 0;
    model_reset();
    cycle(1, 0, 0, OP_ALU, 32'h0, 0, 0);
    cycle(1, 0, 0, OP_ALU, 32'h0, 0, 0);
    // Weakly-not-taken B mispredicts, then trains up to strongly taken.
    cycle(0, 0, 0, OP_B,   32'h40, 0, 0);
    cycle(0, 0, 0, OP_ALU, 32'h44, 0, 0);
    cycle(0, 0, 0, OP_ALU, 32'h48, 1, 1);
    cycle(0, 0, 0, OP_ALU, 32'h4C, 0, 0);
    cycle(0, 0, 0, OP_B,   32'h40, 0, 0);
    cycle(0, 0, 0, OP_ALU, 32'h44, 0, 0);
    cycle(0, 0, 0, OP_ALU, 32'h48, 1, 1);
    cycle(0, 0, 0, OP_B,   32'h40, 0, 0);
    cycle(0, 0, 0, OP_ALU, 32'h44, 1, 1);
    cycle(0, 0, 0, OP_B,   32'h40, 0, 0);
    cycle(0, 0, 0, OP_ALU, 32'h44, 1, 1);
    cycle(0, 0, 0, OP_J,   32'h80, 0, 0);
    // FIFO full -> hold; same-cycle correct resolve releases it.
    cycle(0, 0, 0, OP_B,   32'h04, 0, 0);
    cycle(0, 0, 0, OP_B,   32'h08, 0, 0);
    cycle(0, 0, 0, OP_B,   32'h0C, 0, 0);
    cycle(0, 0, 0, OP_B,   32'h0C, 1, 0);
    // Stalled branch and resolve change nothing.
    cycle(0, 1, 0, OP_B,   32'h10, 1, 1);
    cycle(0, 0, 1, OP_B,   32'h10, 1, 1);
    cycle(0, 0, 0, OP_ALU, 32'h14, 1, 0);
    // Mispredict with a B in IF drops that push.
    cycle(0, 0, 0, OP_B,   32'h18, 1, 1);
    cycle(0, 0, 0, OP_ALU, 32'h1C, 0, 0);
    cycle(0, 0, 0, OP_ALU, 32'h20, 1, 1);
    // Mispredict then reset in the middle of RECOVER.
    cycle(0, 0, 0, OP_B,   32'h24, 0, 0);
    cycle(0, 0, 0, OP_ALU, 32'h28, 1, 1);
    cycle(1, 0, 0, OP_ALU, 32'h2C, 0, 0);
    cycle(0, 0, 0, OP_B,   32'h40, 0, 0);
    cycle(0, 0, 0, OP_ALU, 32'h44, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      op = (r < 4) ? OP_B : (r == 4) ? OP_J : (r < 8) ? OP_ALU : 7'b0110011;
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
            op, {$urandom} & 32'hFFFF_FFFC, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end
    @(negedge clk);
    #3;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
